// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD partial-product accumulator.
package bcd_pkg;

    // One packed BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Largest legal BCD digit value.
    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: a + b + carry_in -> digit and decimal carry.
// Sums above 9 are wrapped by subtracting 10. Illegal input digits are not
// rejected; they follow the same rule.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       cin_i,
    output bcd_digit_t sum_o,
    output logic       cout_o
);

    logic [4:0] raw_sum;
    logic [4:0] adj_sum;

    // Binary sum followed by the decimal correction.
    always_comb begin
        raw_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
        adj_sum = raw_sum - 5'd10;
        if (raw_sum > {1'b0, BCD_MAX}) begin
            sum_o  = adj_sum[3:0];
            cout_o = 1'b1;
        end else begin
            sum_o  = raw_sum[3:0];
            cout_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_pp_accumulator.sv
// Digit-serial decimal accumulator.
// Each shifted BCD partial product is added into the accumulator one digit
// per clock. The adder is shared by all digit positions.
// The result is offered on a valid/ready port after the last partial product.
// Optional build macro BCD_ACC_CHECK_EN adds a sticky err_bcd output.
// err_bcd flags any accepted partial-product digit above 9.
module bcd_pp_accumulator
    import bcd_pkg::*;
#(
    parameter int N_DIGITS   = 5,
    parameter int ACC_DIGITS = 10,
    localparam int SHIFT_W   = $clog2(ACC_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pp_valid,
    output logic                    pp_ready,
    input  logic [4*N_DIGITS-1:0]   pp_data,
    input  logic [SHIFT_W-1:0]      pp_shift,
    input  logic                    pp_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*ACC_DIGITS-1:0] res_data,
    output logic                    res_overflow
`ifdef BCD_ACC_CHECK_EN
    ,
    output logic                    err_bcd
`endif
);

    // Digit index must count through a full ripple across the accumulator.
    // The position adds shift and index with headroom.
    localparam int IDX_W = $clog2(ACC_DIGITS) + 1;
    localparam int P_W   = SHIFT_W + IDX_W + 1;

    acc_state_t              state_q, state_d;
    bcd_digit_t              acc_q [ACC_DIGITS];
    logic [4*N_DIGITS-1:0]   pp_data_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    last_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    ovf_q, ovf_d;

    logic                    accept;
    logic                    acc_we;
    logic                    acc_clr;
    logic [P_W-1:0]          pos;
    logic                    in_range;
    bcd_digit_t              acc_digit;
    bcd_digit_t              pp_digit;
    bcd_digit_t              sum_digit;
    logic                    sum_carry;

    assign accept    = (state_q == IDLE) && pp_valid;
    assign pp_ready  = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign res_overflow = ovf_q;

    assign pos      = P_W'(shift_q) + P_W'(idx_q);
    assign in_range = (pos < P_W'(ACC_DIGITS));

    // Select the accumulator digit at the current position.
    // Out-of-range positions read 0.
    always_comb begin
        acc_digit = '0;
        for (int k = 0; k < ACC_DIGITS; k++) begin
            if (pos == P_W'(k)) begin
                acc_digit = acc_q[k];
            end
        end
    end

    // Select partial-product digit i; indices past the operand contribute 0.
    always_comb begin
        pp_digit = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                pp_digit = pp_data_q[4*k +: 4];
            end
        end
    end

    bcd_digit_add u_digit_add (
        .a_i    (acc_digit),
        .b_i    (pp_digit),
        .cin_i  (carry_q),
        .sum_o  (sum_digit),
        .cout_o (sum_carry)
    );

    // Next-state logic: handshakes, digit stepping, carry ripple and overflow.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        acc_we  = 1'b0;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (pp_valid) begin
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                idx_d = idx_q + IDX_W'(1);
                if (in_range) begin
                    acc_we  = 1'b1;
                    carry_d = sum_carry;
                    // A carry out of the top digit has nowhere to go.
                    if (sum_carry && (pos == P_W'(ACC_DIGITS - 1))) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    // Digits shifted past the top are dropped.
                    // Any nonzero value lost this way is overflow.
                    carry_d = 1'b0;
                    if ((pp_digit != '0) || carry_q) begin
                        ovf_d = 1'b1;
                    end
                end
                // Leave after the operand digits once no carry remains to ripple.
                // A carry at the top digit has already been counted as overflow.
                if ((idx_q >= IDX_W'(N_DIGITS - 1)) &&
                    (!carry_d || (pos >= P_W'(ACC_DIGITS - 1)))) begin
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    acc_clr = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: state, digit index, carry and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Capture the offered partial product on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pp_data_q <= '0;
            shift_q   <= '0;
            last_q    <= 1'b0;
        end else if (accept) begin
            pp_data_q <= pp_data;
            shift_q   <= pp_shift;
            last_q    <= pp_last;
        end
    end

    // Accumulator digits are written only at the current position.
    // Each digit is also exposed directly on the result bus.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_DIGITS; gi++) begin : g_acc
            // Digit register: cleared by reset or result handshake, else written when addressed.
            always_ff @(posedge clk) begin
                if (rst || acc_clr) begin
                    acc_q[gi] <= '0;
                end else if (acc_we && (pos == P_W'(gi))) begin
                    acc_q[gi] <= sum_digit;
                end
            end
            assign res_data[4*gi +: 4] = acc_q[gi];
        end
    endgenerate

`ifdef BCD_ACC_CHECK_EN
    logic err_q;
    logic bad_digit;

    // Flag any non-decimal digit in the offered partial product.
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (pp_data[4*k +: 4] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Sticky error flag: set on acceptance of a bad digit, cleared with the result.
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            err_q <= 1'b0;
        end else if (accept && bad_digit) begin
            err_q <= 1'b1;
        end
    end

    assign err_bcd = err_q;
`endif

endmodule

// File: tb/tb_bcd_pp_accumulator.sv
// Directed testbench for bcd_pp_accumulator (N_DIGITS=5, ACC_DIGITS=10).
// Expected results are BCD values written as hex literals, one nibble per digit.
module tb_bcd_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        pp_valid;
    logic        pp_ready;
    logic [19:0] pp_data;
    logic [3:0]  pp_shift;
    logic        pp_last;
    logic        res_valid;
    logic        res_ready;
    logic [39:0] res_data;
    logic        res_overflow;
`ifdef BCD_ACC_CHECK_EN
    logic        err_bcd;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_pp_accumulator #(
        .N_DIGITS   (5),
        .ACC_DIGITS (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pp_valid     (pp_valid),
        .pp_ready     (pp_ready),
        .pp_data      (pp_data),
        .pp_shift     (pp_shift),
        .pp_last      (pp_last),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow)
`ifdef BCD_ACC_CHECK_EN
        ,
        .err_bcd      (err_bcd)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer one partial product, then count the ADD cycles.
    // The count ends when the block is ready again or shows a result.
    task automatic send_pp(input string tag, input logic [19:0] d, input logic [3:0] sh,
                           input logic last, input int exp_len);
        int waited = 0;
        int len = 0;
        while (!pp_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq({tag, "_ready"}, 64'(pp_ready), 64'd1);
        pp_valid = 1'b1;
        pp_data  = d;
        pp_shift = sh;
        pp_last  = last;
        @(posedge clk); #1;
        pp_valid = 1'b0;
        while (!pp_ready && !res_valid && len < 40) begin
            @(posedge clk); #1;
            len++;
        end
        check_eq({tag, "_addlen"}, 64'(len), 64'(exp_len));
        $display("txn %s: pp=%05h shift=%0d last=%0b add_cycles=%0d acc=%010h",
                 tag, d, sh, last, len, res_data);
    endtask

    // Check the presented result, complete the handshake, and confirm the clear.
    task automatic take_result(input string tag, input logic [39:0] exp_data, input logic exp_ovf);
        check_eq({tag, "_rvalid"}, 64'(res_valid), 64'd1);
        check_eq({tag, "_ppready_done"}, 64'(pp_ready), 64'd0);
        check_eq({tag, "_data"}, 64'(res_data), 64'(exp_data));
        check_eq({tag, "_ovf"}, 64'(res_overflow), 64'(exp_ovf));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_eq({tag, "_rvalid_after"}, 64'(res_valid), 64'd0);
        check_eq({tag, "_ppready_after"}, 64'(pp_ready), 64'd1);
        check_eq({tag, "_cleared"}, 64'(res_data), 64'd0);
        check_eq({tag, "_ovf_cleared"}, 64'(res_overflow), 64'd0);
        $display("txn %s: result taken, expected=%010h ovf=%0b", tag, exp_data, exp_ovf);
    endtask

    initial begin
        rst       = 1'b1;
        pp_valid  = 1'b0;
        pp_data   = '0;
        pp_shift  = '0;
        pp_last   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check_eq("rst_ppready", 64'(pp_ready), 64'd1);
        check_eq("rst_rvalid", 64'(res_valid), 64'd0);
        check_eq("rst_data", 64'(res_data), 64'd0);
        check_eq("rst_ovf", 64'(res_overflow), 64'd0);
`ifdef BCD_ACC_CHECK_EN
        check_eq("rst_err", 64'(err_bcd), 64'd0);
`endif

        // 1: single product, no carries.
        send_pp("t1", 20'h12345, 4'd0, 1'b1, 5);
        take_result("t1", 40'h0000012345, 1'b0);

        // 2: 99999 + 999990. The second ADD ripples into digit 6, so it takes 6 cycles.
        send_pp("t2a", 20'h99999, 4'd0, 1'b0, 5);
        send_pp("t2b", 20'h99999, 4'd1, 1'b1, 6);
        take_result("t2", 40'h0001099989, 1'b0);

        // 3: 99999 + 1. The carry leaves digit 4 and is deposited in digit 5.
        // That adds one step after the five operand digits.
        send_pp("t3a", 20'h99999, 4'd0, 1'b0, 5);
        send_pp("t3b", 20'h00001, 4'd0, 1'b1, 6);
        take_result("t3", 40'h0000100000, 1'b0);

        // 4: the top carry is lost, so overflow is set.
        send_pp("t4a", 20'h99999, 4'd5, 1'b0, 5);
        send_pp("t4b", 20'h99999, 4'd5, 1'b1, 5);
        take_result("t4", 40'h9999800000, 1'b1);

        // Nonzero digit shifted above the top digit.
        send_pp("t4c", 20'h00012, 4'd9, 1'b1, 5);
        take_result("t4c", 40'h2000000000, 1'b1);

        // 5: result held while the consumer stalls; the next product starts from 0.
        send_pp("t5a", 20'h00042, 4'd3, 1'b1, 5);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("t5_hold_valid", 64'(res_valid), 64'd1);
            check_eq("t5_hold_data", 64'(res_data), 64'h0000042000);
            check_eq("t5_hold_ppready", 64'(pp_ready), 64'd0);
        end
        take_result("t5a", 40'h0000042000, 1'b0);
        send_pp("t5b", 20'h00003, 4'd0, 1'b1, 5);
        take_result("t5b", 40'h0000000003, 1'b0);

        // 6: reset in the middle of an ADD.
        send_pp("t6a", 20'h99999, 4'd0, 1'b0, 5);
        pp_valid = 1'b1;
        pp_data  = 20'h99999;
        pp_shift = 4'd5;
        pp_last  = 1'b1;
        @(posedge clk); #1;
        pp_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_in_add", 64'(pp_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t6_ppready", 64'(pp_ready), 64'd1);
        check_eq("t6_rvalid", 64'(res_valid), 64'd0);
        check_eq("t6_data", 64'(res_data), 64'd0);
        check_eq("t6_ovf", 64'(res_overflow), 64'd0);
        $display("txn t6: reset during ADD");
        send_pp("t6b", 20'h00007, 4'd0, 1'b1, 5);
        take_result("t6b", 40'h0000000007, 1'b0);

`ifdef BCD_ACC_CHECK_EN
        // Illegal digit A: wraps to 0 and carries 1, so the result is 10.
        send_pp("terr", 20'h0000A, 4'd0, 1'b1, 5);
        check_eq("terr_set", 64'(err_bcd), 64'd1);
        take_result("terr", 40'h0000000010, 1'b0);
        check_eq("terr_cleared", 64'(err_bcd), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
